// File: rtl/game_sequencer.sv
// Gameplay controller: sequences attract / play / hit / game-over phases and
// owns lives, score, invulnerability timer and dragon length requests.
module game_sequencer #(
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 120,
    parameter int FLASH_BIT     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_end,
    input  logic       start_btn,
    input  logic       player_dragon_collision,
    input  logic       sword_dragon_collision,
    input  logic       sheep_dragon_collision,
    output logic [1:0] game_state,
    output logic [1:0] player_lives,
    output logic [7:0] score,
    output logic       game_reset,
    output logic       logic_enable,
    output logic       player_visible,
    output logic [1:0] length_update
);

    localparam logic [1:0] ST_ATTRACT = 2'b00;
    localparam logic [1:0] ST_PLAY    = 2'b01;
    localparam logic [1:0] ST_HIT     = 2'b10;
    localparam logic [1:0] ST_OVER    = 2'b11;

    localparam logic [1:0] LEN_NONE   = 2'b00;
    localparam logic [1:0] LEN_GROW   = 2'b01;
    localparam logic [1:0] LEN_SHRINK = 2'b10;

    localparam logic [1:0] START_LIVES_L = 2'(START_LIVES);
    localparam logic [7:0] INVULN_L      = 8'(INVULN_FRAMES);

    logic [1:0] state_r;
    logic [1:0] lives_r;
    logic [7:0] score_r;
    logic [7:0] timer_r;
    logic       start_prev_r;
    logic       game_reset_r;
    logic       logic_enable_r;
    logic       visible_r;
    logic [1:0] length_update_r;

    logic [1:0] state_s;
    logic [1:0] lives_s;
    logic [7:0] score_s;
    logic [7:0] timer_s;
    logic       start_prev_s;
    logic       game_reset_s;
    logic       logic_enable_s;
    logic       visible_s;
    logic [1:0] length_update_s;
    logic       start_edge_s;
    logic       dead_s;
    logic [7:0] timer_dec_s;

    assign start_edge_s = start_btn & ~start_prev_r;
    assign timer_dec_s  = timer_r - 8'd1;

    // Next-state and per-frame bookkeeping; everything advances only on frame_end.
    always_comb begin
        state_s         = state_r;
        lives_s         = lives_r;
        score_s         = score_r;
        timer_s         = timer_r;
        start_prev_s    = start_prev_r;
        visible_s       = visible_r;
        game_reset_s    = 1'b0;
        length_update_s = LEN_NONE;
        dead_s          = 1'b0;

        if (frame_end) begin
            start_prev_s = start_btn;
            case (state_r)
                ST_ATTRACT, ST_OVER: begin
                    if (start_edge_s) begin
                        state_s      = ST_PLAY;
                        lives_s      = START_LIVES_L;
                        score_s      = 8'd0;
                        game_reset_s = 1'b1;
                        visible_s    = 1'b1;
                    end else begin
                        visible_s    = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (player_dragon_collision) begin
                        if (lives_r > 2'd1) begin
                            lives_s = lives_r - 2'd1;
                            timer_s = INVULN_L;
                            state_s = ST_HIT;
                        end else begin
                            lives_s   = 2'd0;
                            state_s   = ST_OVER;
                            visible_s = 1'b1;
                            dead_s    = 1'b1;
                        end
                    end else begin
                        visible_s = 1'b1;
                    end
                end
                ST_HIT: begin
                    timer_s = timer_dec_s;
                    if (timer_dec_s == 8'd0) begin
                        state_s   = ST_PLAY;
                        visible_s = 1'b1;
                    end else begin
                        visible_s = ~timer_dec_s[FLASH_BIT];
                    end
                end
                default: begin
                    state_s = ST_ATTRACT;
                end
            endcase

            // Sword beats sheep for the single length request; a fatal hit suppresses both.
            if (((state_r == ST_PLAY) || (state_r == ST_HIT)) && !dead_s) begin
                if (sword_dragon_collision) begin
                    length_update_s = LEN_SHRINK;
                    if (score_r != 8'hFF) begin
                        score_s = score_r + 8'd1;
                    end else begin
                        score_s = score_r;
                    end
                end else if (sheep_dragon_collision) begin
                    length_update_s = LEN_GROW;
                end else begin
                    length_update_s = LEN_NONE;
                end
            end else begin
                length_update_s = LEN_NONE;
            end
        end else begin
            start_prev_s = start_prev_r;
        end

        logic_enable_s = (state_s == ST_PLAY) || (state_s == ST_HIT);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_ATTRACT;
            lives_r         <= START_LIVES_L;
            score_r         <= 8'd0;
            timer_r         <= 8'd0;
            start_prev_r    <= 1'b0;
            game_reset_r    <= 1'b0;
            logic_enable_r  <= 1'b0;
            visible_r       <= 1'b1;
            length_update_r <= LEN_NONE;
        end else begin
            state_r         <= state_s;
            lives_r         <= lives_s;
            score_r         <= score_s;
            timer_r         <= timer_s;
            start_prev_r    <= start_prev_s;
            game_reset_r    <= game_reset_s;
            logic_enable_r  <= logic_enable_s;
            visible_r       <= visible_s;
            length_update_r <= length_update_s;
        end
    end

    assign game_state     = state_r;
    assign player_lives   = lives_r;
    assign score          = score_r;
    assign game_reset     = game_reset_r;
    assign logic_enable   = logic_enable_r;
    assign player_visible = visible_r;
    assign length_update  = length_update_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed + randomized bench for game_sequencer against a frame-level game model.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_end = 1'b0;
    logic       start_btn = 1'b0;
    logic       pdc = 1'b0;
    logic       sdc = 1'b0;
    logic       shc = 1'b0;
    logic [1:0] game_state;
    logic [1:0] player_lives;
    logic [7:0] score;
    logic       game_reset;
    logic       logic_enable;
    logic       player_visible;
    logic [1:0] length_update;

    int checks = 0;
    int failures = 0;

    // Reference model: plain integers, updated per frame from the game rules.
    int m_state, m_lives, m_score, m_timer, m_vis, m_prev, e_greset, e_len;

    game_sequencer dut (
        .clk(clk), .rst_n(rst_n), .frame_end(frame_end), .start_btn(start_btn),
        .player_dragon_collision(pdc), .sword_dragon_collision(sdc),
        .sheep_dragon_collision(shc), .game_state(game_state),
        .player_lives(player_lives), .score(score), .game_reset(game_reset),
        .logic_enable(logic_enable), .player_visible(player_visible),
        .length_update(length_update)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, int'(game_state), m_state);
        chk({tag, ".lives"}, int'(player_lives), m_lives);
        chk({tag, ".score"}, int'(score), m_score);
        chk({tag, ".enable"}, int'(logic_enable), (m_state == 1 || m_state == 2) ? 1 : 0);
        chk({tag, ".visible"}, int'(player_visible), m_vis);
        chk({tag, ".reset_pulse"}, int'(game_reset), e_greset);
        chk({tag, ".length"}, int'(length_update), e_len);
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = 3; m_score = 0; m_timer = 0;
        m_vis = 1; m_prev = 0; e_greset = 0; e_len = 0;
    endtask

    task automatic model_frame(input int sb, input int pc, input int sw, input int sh);
        int edge_hit;
        int dead;
        edge_hit = (sb == 1 && m_prev == 0) ? 1 : 0;
        m_prev = sb;
        e_greset = 0; e_len = 0; dead = 0;
        if (m_state == 0 || m_state == 3) begin
            if (edge_hit == 1) begin
                m_state = 1; m_lives = 3; m_score = 0; e_greset = 1; m_vis = 1;
            end
        end else begin
            if (m_state == 1 && pc == 1) begin
                if (m_lives > 1) begin
                    m_lives = m_lives - 1; m_timer = 120; m_state = 2;
                end else begin
                    m_lives = 0; m_state = 3; dead = 1;
                end
            end else if (m_state == 2) begin
                m_timer = m_timer - 1;
                if (m_timer == 0) begin
                    m_state = 1; m_vis = 1;
                end else begin
                    m_vis = ((m_timer / 8) % 2 == 0) ? 1 : 0;
                end
            end
            if (dead == 0) begin
                if (sw == 1) begin
                    e_len = 2;
                    if (m_score < 255) m_score = m_score + 1;
                end else if (sh == 1) begin
                    e_len = 1;
                end
            end
        end
    endtask

    // One frame: a frame_end cycle, then an idle cycle with noise on the collision inputs.
    task automatic do_frame(input int sb, input int pc, input int sw, input int sh);
        @(negedge clk);
        start_btn = sb[0]; pdc = pc[0]; sdc = sw[0]; shc = sh[0]; frame_end = 1'b1;
        @(posedge clk); #1;
        model_frame(sb, pc, sw, sh);
        check_all("frame");
        @(negedge clk);
        frame_end = 1'b0;
        pdc = 1'($urandom_range(0, 1));
        sdc = 1'($urandom_range(0, 1));
        shc = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        e_greset = 0; e_len = 0;
        check_all("idle");
    endtask

    task automatic expire_hit(input int sb);
        for (int i = 0; i < 120; i++) begin
            do_frame(sb, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Held start: one game_reset only.
        for (int i = 0; i < 3; i++) do_frame(1, 0, 0, 0);
        chk("held_start.state", int'(game_state), 1);
        do_frame(0, 0, 0, 0);

        // First hit, collisions ignored during HIT, timed return to PLAY.
        do_frame(0, 1, 0, 0);
        chk("hit.lives", int'(player_lives), 2);
        expire_hit(0);
        chk("hit_expired.state", int'(game_state), 1);
        chk("hit_expired.lives", int'(player_lives), 2);

        do_frame(0, 1, 0, 0);
        expire_hit(0);
        do_frame(0, 1, 1, 1);
        chk("over.state", int'(game_state), 3);
        chk("over.lives", int'(player_lives), 0);

        // Restart, then length request priority.
        do_frame(1, 0, 0, 0);
        do_frame(0, 0, 1, 1);
        chk("shrink.length_seen_next_cycle", int'(length_update), 0);
        do_frame(0, 0, 0, 1);

        // Score saturation.
        for (int i = 0; i < 260; i++) do_frame(0, 0, 1, int'($urandom_range(0, 1)));
        chk("saturate.score", int'(score), 255);

        // Asynchronous reset part-way through HIT, off the clock edge.
        do_frame(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) do_frame(0, 0, 0, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Play to OVER with start held; restart needs release then press.
        do_frame(1, 0, 0, 0);
        do_frame(1, 1, 0, 0);
        expire_hit(1);
        do_frame(1, 1, 0, 0);
        expire_hit(1);
        do_frame(1, 1, 1, 0);
        chk("held_over.state", int'(game_state), 3);
        do_frame(1, 0, 0, 0);
        do_frame(1, 0, 0, 0);
        do_frame(0, 0, 0, 0);
        do_frame(1, 0, 0, 0);
        chk("restart.lives", int'(player_lives), 3);
        chk("restart.score", int'(score), 0);

        // Randomized play with rare player hits.
        for (int i = 0; i < 400; i++) begin
            do_frame(int'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0) ? 1 : 0,
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
